// File: rtl/uart_rom_loader_if.sv
// ROM download stream from the UART loader to the SMS top-level.
interface uart_rom_loader_if;
   logic       rom_loading;
   logic [7:0] rom_do;
   logic       rom_do_valid;

   modport master (output rom_loading, output rom_do, output rom_do_valid);
   modport slave  (input  rom_loading, input  rom_do, input  rom_do_valid);
endinterface

// File: rtl/uart_rom_loader.sv
// UART cartridge loader: receives a framed, checksummed image over 8N1 serial
// and replays its payload as the ROM download byte stream.
module uart_rom_loader #(
   parameter int unsigned FREQ    = 53_700_000,
   parameter int unsigned BAUD    = 115200,
   parameter int unsigned TIMEOUT = 5_370_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               uart_rx,
   uart_rom_loader_if.master  rom,
   output logic               done,
   output logic               error
);

   localparam int unsigned DIV  = FREQ / BAUD;
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV + 1);
   localparam int unsigned TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      F_SYNC0, F_SYNC1, F_LEN0, F_LEN1, F_LEN2, F_DATA, F_CSUM
   } fr_state_t;

   // receiver
   logic          r_rx_meta, r_rx_sync, r_rx_prev;
   rx_state_t     r_rx_state;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_rx_byte;
   logic          r_rx_stb, r_rx_ferr;

   // frame tracking
   fr_state_t     r_fr_state;
   logic [22:0]   r_len;
   logic [21:0]   r_cnt;
   logic [7:0]    r_sum;
   logic [TW-1:0] r_tmo;

   logic [23:0]   w_len_n;
   logic          w_len_bad;
   logic [22:0]   w_cnt_inc;
   logic          w_last;
   logic          w_timeout;
   logic          w_abort;

   assign w_len_n   = {r_rx_byte, r_len[15:0]};
   assign w_len_bad = (w_len_n == 24'd0) || (w_len_n > 24'h40_0000);
   assign w_cnt_inc = {1'b0, r_cnt} + 23'd1;
   assign w_last    = (w_cnt_inc == r_len);
   assign w_timeout = (r_tmo == TW'(TIMEOUT));
   assign w_abort   = (r_fr_state != F_SYNC0) && (r_rx_ferr || w_timeout);

   // Synchronize the line and deserialize 8N1 bytes, mid-bit sampled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_rx_byte  <= '0;
         r_rx_stb   <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_stb  <= 1'b0;
         r_rx_ferr <= 1'b0;
         r_rx_meta <= uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
         case (r_rx_state)
            RX_IDLE: begin
               if (r_rx_prev && !r_rx_sync) begin
                  r_rx_state <= RX_START;
                  r_baud_cnt <= '0;
               end
            end
            RX_START: begin
               if (r_baud_cnt == CW'(HALF - 1)) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  // a line already back high was a glitch, not a start bit
                  r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (r_baud_cnt == CW'(DIV - 1)) begin
                  r_baud_cnt <= '0;
                  r_shift    <= {r_rx_sync, r_shift[7:1]};
                  r_bit_idx  <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (r_baud_cnt == CW'(DIV - 1)) begin
                  r_baud_cnt <= '0;
                  r_rx_state <= RX_IDLE;
                  if (r_rx_sync) begin
                     r_rx_stb  <= 1'b1;
                     r_rx_byte <= r_shift;
                  end else begin
                     r_rx_ferr <= 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // Frame parser: sync, length, payload replay, checksum and abort handling.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fr_state       <= F_SYNC0;
         r_len            <= '0;
         r_cnt            <= '0;
         r_sum            <= '0;
         r_tmo            <= '0;
         rom.rom_loading  <= 1'b0;
         rom.rom_do       <= '0;
         rom.rom_do_valid <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
      end else begin
         rom.rom_do_valid <= 1'b0;
         if (r_fr_state == F_SYNC0 || r_rx_stb) r_tmo <= '0;
         else if (!w_timeout)                  r_tmo <= r_tmo + TW'(1);

         if (w_abort) begin
            // abort outranks a byte arriving in the same cycle
            error           <= 1'b1;
            rom.rom_loading <= 1'b0;
            r_fr_state      <= F_SYNC0;
         end else if (r_rx_stb) begin
            case (r_fr_state)
               F_SYNC0: if (r_rx_byte == 8'hA5) r_fr_state <= F_SYNC1;
               F_SYNC1: begin
                  if (r_rx_byte == 8'h5A) begin
                     r_fr_state <= F_LEN0;
                     done       <= 1'b0;
                     error      <= 1'b0;
                  end else if (r_rx_byte != 8'hA5) begin
                     r_fr_state <= F_SYNC0;
                  end
               end
               F_LEN0: begin
                  r_len[7:0] <= r_rx_byte;
                  r_fr_state <= F_LEN1;
               end
               F_LEN1: begin
                  r_len[15:8] <= r_rx_byte;
                  r_fr_state  <= F_LEN2;
               end
               F_LEN2: begin
                  r_len <= w_len_n[22:0];
                  if (w_len_bad) begin
                     error      <= 1'b1;
                     r_fr_state <= F_SYNC0;
                  end else begin
                     rom.rom_loading <= 1'b1;
                     r_cnt           <= '0;
                     r_sum           <= '0;
                     r_fr_state      <= F_DATA;
                  end
               end
               F_DATA: begin
                  rom.rom_do       <= r_rx_byte;
                  rom.rom_do_valid <= 1'b1;
                  r_sum            <= r_sum + r_rx_byte;
                  r_cnt            <= w_cnt_inc[21:0];
                  if (w_last) r_fr_state <= F_CSUM;
               end
               F_CSUM: begin
                  if (r_sum == r_rx_byte) done  <= 1'b1;
                  else                    error <= 1'b1;
                  rom.rom_loading <= 1'b0;
                  r_fr_state      <= F_SYNC0;
               end
               default: r_fr_state <= F_SYNC0;
            endcase
         end
      end
   end

endmodule
